// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encoding, tag width and op decode for pipelined_shifter (option: PIPELINED_SHIFTER_ROTATE_EN)
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL  = 3'd0,
    SRL  = 3'd1,
    SRA  = 3'd2,
    ROTR = 3'd3,
    ROTL = 3'd4
  } shift_op_t;

  localparam int TAG_W = 5;

  // Reduce a raw op code to the ops the level muxes implement.
  // ROTL leaves here as ROTR; its amount is negated separately at acceptance.
  function automatic shift_op_t normalize_op(input logic [2:0] op);
    shift_op_t res;
    case (op)
      3'd1: res = SRL;
      3'd2: res = SRA;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      3'd3, 3'd4: res = ROTR;
`else
      3'd3, 3'd4: res = SRL;
`endif
      default: res = SLL;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one combinational shift/rotate level by DIST (rotate mux under PIPELINED_SHIFTER_ROTATE_EN)
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  shift_op_t        op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // Shift by DIST when this level's amount bit is set, otherwise pass through.
  always_comb begin
    result = data;
    if (enable) begin
      case (op)
        SLL:      result = data << DIST;
        SRL, SRA: result = {{DIST{fill}}, data[WIDTH-1:DIST]};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        ROTR:     result = {data[DIST-1:0], data[WIDTH-1:DIST]};
`endif
        default:  result = data << DIST;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined shifter/rotator with valid/ready and flush (rotates under PIPELINED_SHIFTER_ROTATE_EN)
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int  WIDTH  = 32,
  parameter int  STAGES = 2,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = SHW;

  // Stage registers: what each stage hands to the next one.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] data_q  [STAGES];
  shift_op_t        op_q    [STAGES];
  logic [SHW-1:0]   amt_q   [STAGES];
  logic             fill_q  [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];

  // Inputs seen by each stage's levels, and the data they produce.
  logic [WIDTH-1:0] stg_data [STAGES];
  shift_op_t        stg_op   [STAGES];
  logic [SHW-1:0]   stg_amt  [STAGES];
  logic             stg_fill [STAGES];
  logic [TAG_W-1:0] stg_tag  [STAGES];
  logic [WIDTH-1:0] stg_res  [STAGES];

  shift_op_t        head_op;
  logic [SHW-1:0]   head_amt;
  logic             head_fill;
  logic             advance;
  logic             accept;

  assign head_op = normalize_op(in_op);

`ifdef PIPELINED_SHIFTER_ROTATE_EN
  // ROTL by n equals ROTR by (WIDTH - n) mod WIDTH; the modulo falls out of SHW-bit arithmetic.
  assign head_amt = (in_op == ROTL) ? SHW'(-in_amount) : in_amount;
`else
  assign head_amt = in_amount;
`endif

  // The sign bit is frozen here so later stages never look at the original operand.
  assign head_fill = (head_op == SRA) && in_data[WIDTH-1];

  // A single global enable: everything moves unless the output is stalled.
  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance && !flush;
  assign accept   = in_valid && in_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * LEVELS / STAGES;
    localparam int HI = (s == STAGES - 1) ? LEVELS : (s + 1) * LEVELS / STAGES;

    logic [WIDTH-1:0] chain [LO:HI];

    if (s == 0) begin : g_head
      assign stg_data[s] = in_data;
      assign stg_op[s]   = head_op;
      assign stg_amt[s]  = head_amt;
      assign stg_fill[s] = head_fill;
      assign stg_tag[s]  = in_tag;
    end else begin : g_body
      assign stg_data[s] = data_q[s-1];
      assign stg_op[s]   = op_q[s-1];
      assign stg_amt[s]  = amt_q[s-1];
      assign stg_fill[s] = fill_q[s-1];
      assign stg_tag[s]  = tag_q[s-1];
    end

    assign chain[LO] = stg_data[s];

    for (genvar l = LO; l < HI; l++) begin : g_level
      shift_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << l)
      ) u_level (
        .data   (chain[l]),
        .enable (stg_amt[s][l]),
        .op     (stg_op[s]),
        .fill   (stg_fill[s]),
        .result (chain[l+1])
      );
    end

    assign stg_res[s] = chain[HI];
  end

  // Pipeline registers: flush kills valids, otherwise all stages move together on advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        op_q[i]    <= SLL;
        amt_q[i]   <= '0;
        fill_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (advance) begin
      valid_q[0] <= accept;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= stg_res[i];
        op_q[i]   <= stg_op[i];
        amt_q[i]  <= stg_amt[i];
        fill_q[i] <= stg_fill[i];
        tag_q[i]  <= stg_tag[i];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed table and sequence bench for pipelined_shifter (rotate checks follow PIPELINED_SHIFTER_ROTATE_EN)
module tb_pipelined_shifter;
  import shifter_pkg::*;

  logic clock;
  logic reset;

  logic        c32_flush, c32_in_valid, c32_in_ready, c32_out_valid, c32_out_ready;
  logic [31:0] c32_in_data, c32_out_data;
  logic [4:0]  c32_in_amount;
  logic [2:0]  c32_in_op;
  logic [4:0]  c32_in_tag, c32_out_tag;

  logic        c64_flush, c64_in_valid, c64_in_ready, c64_out_valid, c64_out_ready;
  logic [63:0] c64_in_data, c64_out_data;
  logic [5:0]  c64_in_amount;
  logic [2:0]  c64_in_op;
  logic [4:0]  c64_in_tag, c64_out_tag;

  int n_vec;
  int n_bad;

  pipelined_shifter #(.WIDTH(32), .STAGES(2)) u_dut32 (
    .clock     (clock),
    .reset     (reset),
    .flush     (c32_flush),
    .in_valid  (c32_in_valid),
    .in_ready  (c32_in_ready),
    .in_data   (c32_in_data),
    .in_amount (c32_in_amount),
    .in_op     (c32_in_op),
    .in_tag    (c32_in_tag),
    .out_valid (c32_out_valid),
    .out_ready (c32_out_ready),
    .out_data  (c32_out_data),
    .out_tag   (c32_out_tag)
  );

  pipelined_shifter #(.WIDTH(64), .STAGES(3)) u_dut64 (
    .clock     (clock),
    .reset     (reset),
    .flush     (c64_flush),
    .in_valid  (c64_in_valid),
    .in_ready  (c64_in_ready),
    .in_data   (c64_in_data),
    .in_amount (c64_in_amount),
    .in_op     (c64_in_op),
    .in_tag    (c64_in_tag),
    .out_valid (c64_out_valid),
    .out_ready (c64_out_ready),
    .out_data  (c64_out_data),
    .out_tag   (c64_out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] data,
                              input logic [4:0] amt, input logic [4:0] tag,
                              input logic [31:0] exp);
    vec_t v;
    v.op = op; v.data = data; v.amt = amt; v.tag = tag; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run32(input string name, input vec_t v);
    int lat;
    @(negedge clock);
    c32_in_valid  = 1'b1;
    c32_in_op     = v.op;
    c32_in_data   = v.data;
    c32_in_amount = v.amt;
    c32_in_tag    = v.tag;
    c32_out_ready = 1'b1;
    #1 check({name, " in_ready"}, 64'(c32_in_ready), 64'd1);
    @(negedge clock);
    c32_in_valid = 1'b0;
    lat = 1;
    while (!c32_out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd2);
    check({name, " data"}, 64'(c32_out_data), 64'(v.exp));
    check({name, " tag"}, 64'(c32_out_tag), 64'(v.tag));
  endtask

  task automatic drive64(input logic [2:0] op, input logic [63:0] data,
                         input logic [5:0] amt, input logic [4:0] tag);
    c64_in_valid  = 1'b1;
    c64_in_op     = op;
    c64_in_data   = data;
    c64_in_amount = amt;
    c64_in_tag    = tag;
  endtask

  task automatic run64(input string name, input logic [2:0] op, input logic [63:0] data,
                       input logic [5:0] amt, input logic [4:0] tag, input logic [63:0] exp);
    int lat;
    @(negedge clock);
    drive64(op, data, amt, tag);
    c64_out_ready = 1'b1;
    #1 check({name, " in_ready"}, 64'(c64_in_ready), 64'd1);
    @(negedge clock);
    c64_in_valid = 1'b0;
    lat = 1;
    while (!c64_out_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd3);
    check({name, " data"}, c64_out_data, exp);
    check({name, " tag"}, 64'(c64_out_tag), 64'(tag));
  endtask

  initial begin
    logic [31:0] bp_exp [6];
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;
    logic        held;
    int          nxt;
    int          got;

    n_vec = 0;
    n_bad = 0;

    vt.push_back(mk(SLL,  32'h0000_0001, 5'd31, 5'd3,  32'h8000_0000));
    vt.push_back(mk(SRA,  32'h8000_0000, 5'd4,  5'd4,  32'hF800_0000));
    vt.push_back(mk(SRL,  32'h8000_0000, 5'd4,  5'd5,  32'h0800_0000));
    vt.push_back(mk(SLL,  32'h1234_5678, 5'd0,  5'd6,  32'h1234_5678));
    vt.push_back(mk(SRA,  32'h8765_4321, 5'd0,  5'd7,  32'h8765_4321));
    vt.push_back(mk(SRL,  32'hFFFF_FFFF, 5'd31, 5'd8,  32'h0000_0001));
    vt.push_back(mk(SRA,  32'h7FFF_FFFF, 5'd30, 5'd9,  32'h0000_0001));
    vt.push_back(mk(SRA,  32'h8000_0000, 5'd31, 5'd10, 32'hFFFF_FFFF));
    vt.push_back(mk(SRA,  32'h8000_0001, 5'd1,  5'd11, 32'hC000_0000));
    vt.push_back(mk(SLL,  32'hF0F0_F0F0, 5'd4,  5'd12, 32'h0F0F_0F00));
    vt.push_back(mk(3'd5, 32'h0000_0001, 5'd8,  5'd13, 32'h0000_0100));
    vt.push_back(mk(3'd7, 32'h0000_0003, 5'd1,  5'd14, 32'h0000_0006));
    vt.push_back(mk(ROTR, 32'hDEAD_BEEF, 5'd0,  5'd15, 32'hDEAD_BEEF));
    vt.push_back(mk(ROTL, 32'hDEAD_BEEF, 5'd0,  5'd16, 32'hDEAD_BEEF));
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    vt.push_back(mk(ROTR, 32'h0000_0001, 5'd1,  5'd17, 32'h8000_0000));
    vt.push_back(mk(ROTL, 32'h8000_0000, 5'd1,  5'd18, 32'h0000_0001));
    vt.push_back(mk(ROTR, 32'h1234_5678, 5'd8,  5'd19, 32'h7812_3456));
    vt.push_back(mk(ROTL, 32'h1234_5678, 5'd8,  5'd20, 32'h3456_7812));
`else
    vt.push_back(mk(ROTR, 32'h0000_0001, 5'd1,  5'd17, 32'h0000_0000));
    vt.push_back(mk(ROTL, 32'h8000_0000, 5'd1,  5'd18, 32'h4000_0000));
    vt.push_back(mk(ROTR, 32'h1234_5678, 5'd8,  5'd19, 32'h0012_3456));
    vt.push_back(mk(ROTL, 32'h1234_5678, 5'd8,  5'd20, 32'h0012_3456));
`endif

    bp_exp = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40};

    reset = 1'b1;
    c32_flush = 1'b0; c32_in_valid = 1'b0; c32_out_ready = 1'b1;
    c32_in_data = '0; c32_in_amount = '0; c32_in_op = '0; c32_in_tag = '0;
    c64_flush = 1'b0; c64_in_valid = 1'b0; c64_out_ready = 1'b1;
    c64_in_data = '0; c64_in_amount = '0; c64_in_op = '0; c64_in_tag = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst out_valid32", 64'(c32_out_valid), 64'd0);
    check("rst out_data32", 64'(c32_out_data), 64'd0);
    check("rst out_tag32", 64'(c32_out_tag), 64'd0);
    check("rst out_valid64", 64'(c64_out_valid), 64'd0);
    check("rst out_data64", c64_out_data, 64'd0);
    reset = 1'b0;
    #1;
    check("rst in_ready32", 64'(c32_in_ready), 64'd1);
    check("rst in_ready64", 64'(c64_in_ready), 64'd1);

    // Table of single operations on the 32-bit, 2-stage instance.
    for (int i = 0; i < vt.size(); i++) begin
      run32($sformatf("vec%0d", i), vt[i]);
    end

    // Backpressure: output stalled for 5 cycles while requests keep coming.
    nxt = 0; got = 0; held = 1'b0; prev_data = '0; prev_tag = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      c32_out_ready = !(c >= 3 && c < 8);
      if (nxt < 6) begin
        c32_in_valid  = 1'b1;
        c32_in_op     = SLL;
        c32_in_data   = 32'h1;
        c32_in_amount = 5'(nxt + 1);
        c32_in_tag    = 5'(nxt + 1);
      end else begin
        c32_in_valid = 1'b0;
      end
      #1;
      if (c32_out_valid && !c32_out_ready) begin
        check("bp in_ready", 64'(c32_in_ready), 64'd0);
        if (held) begin
          check("bp hold data", 64'(c32_out_data), 64'(prev_data));
          check("bp hold tag", 64'(c32_out_tag), 64'(prev_tag));
        end
        held = 1'b1;
        prev_data = c32_out_data;
        prev_tag  = c32_out_tag;
      end else begin
        held = 1'b0;
      end
      if (c32_out_valid && c32_out_ready) begin
        if (got < 6) begin
          check($sformatf("bp result%0d data", got), 64'(c32_out_data), 64'(bp_exp[got]));
          check($sformatf("bp result%0d tag", got), 64'(c32_out_tag), 64'(got + 1));
        end
        got++;
      end
      if (c32_in_valid && c32_in_ready) nxt++;
    end
    check("bp results delivered", 64'(got), 64'd6);
    c32_out_ready = 1'b1;

    // 64-bit, 3 stages: back-to-back issue, results in order on consecutive cycles.
    @(negedge clock);
    c64_out_ready = 1'b1;
    drive64(SLL, 64'h1, 6'd63, 5'd1);
    #1 check("b2b in_ready0", 64'(c64_in_ready), 64'd1);
    @(negedge clock);
    drive64(SRL, 64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 5'd2);
    #1 check("b2b in_ready1", 64'(c64_in_ready), 64'd1);
    @(negedge clock);
    drive64(SRA, 64'h8000_0000_0000_0000, 6'd63, 5'd3);
    #1 check("b2b in_ready2", 64'(c64_in_ready), 64'd1);
    @(negedge clock);
    c64_in_valid = 1'b0;
    check("b2b r0 valid", 64'(c64_out_valid), 64'd1);
    check("b2b r0 data", c64_out_data, 64'h8000_0000_0000_0000);
    check("b2b r0 tag", 64'(c64_out_tag), 64'd1);
    @(negedge clock);
    check("b2b r1 valid", 64'(c64_out_valid), 64'd1);
    check("b2b r1 data", c64_out_data, 64'h0000_0000_FFFF_FFFF);
    check("b2b r1 tag", 64'(c64_out_tag), 64'd2);
    @(negedge clock);
    check("b2b r2 valid", 64'(c64_out_valid), 64'd1);
    check("b2b r2 data", c64_out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b r2 tag", 64'(c64_out_tag), 64'd3);
    @(negedge clock);
    check("b2b drained", 64'(c64_out_valid), 64'd0);

    run64("v64 sll0", SLL, 64'hCAFE_F00D_1234_5678, 6'd0, 5'd4, 64'hCAFE_F00D_1234_5678);

    // Flush with two operations in flight.
    @(negedge clock);
    drive64(SLL, 64'h1, 6'd1, 5'd7);
    @(negedge clock);
    drive64(SLL, 64'h1, 6'd2, 5'd8);
    @(negedge clock);
    drive64(SLL, 64'h1, 6'd3, 5'd9);
    c64_flush = 1'b1;
    #1 check("flush in_ready", 64'(c64_in_ready), 64'd0);
    @(negedge clock);
    c64_flush = 1'b0;
    c64_in_valid = 1'b0;
    check("flush out_valid", 64'(c64_out_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("flush no stale%0d", k), 64'(c64_out_valid), 64'd0);
    end
    run64("after flush", SRA, 64'h8000_0000_0000_0000, 6'd1, 5'd10, 64'hC000_0000_0000_0000);

    // Asynchronous reset with two operations in flight.
    @(negedge clock);
    drive64(SLL, 64'h1, 6'd4, 5'd11);
    @(negedge clock);
    drive64(SLL, 64'h1, 6'd5, 5'd12);
    @(negedge clock);
    c64_in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("areset out_valid", 64'(c64_out_valid), 64'd0);
    check("areset out_data", c64_out_data, 64'd0);
    check("areset out_tag", 64'(c64_out_tag), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("areset in_ready", 64'(c64_in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("areset no stale%0d", k), 64'(c64_out_valid), 64'd0);
    end
    run64("after reset", SRL, 64'h0123_4567_89AB_CDEF, 6'd4, 5'd13, 64'h0012_3456_789A_BCDE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
